// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy controller: width helpers, default widths
// and the defuzzification state encoding.
package fuzzy_pkg;

  // Ceiling log2 for elaboration-time width math; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Numerator accumulator width: sum of NUM_SETS products of MU_W x POS_W.
  function automatic int num_width(input int num_sets, input int mu_w, input int pos_w);
    return pos_w + mu_w + clog2(num_sets);
  endfunction

  // Denominator accumulator width: sum of NUM_SETS memberships.
  function automatic int den_width(input int num_sets, input int mu_w);
    return mu_w + clog2(num_sets);
  endfunction

  localparam int NUM_SETS_DEF = 4;
  localparam int MU_W_DEF     = 10;
  localparam int POS_W_DEF    = 10;
  localparam int NUM_W        = num_width(NUM_SETS_DEF, MU_W_DEF, POS_W_DEF);
  localparam int DEN_W        = den_width(NUM_SETS_DEF, MU_W_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } defuzz_state_t;

endpackage

// File: rtl/fuzzy_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The caller guarantees the quotient fits Q_W bits, i.e. the dividend bits
// above Q_W are already smaller than the divisor; they seed the partial
// remainder so only Q_W iterations are needed. The first bit is resolved
// on the start edge, so done_o pulses Q_W-1 cycles after start is taken.
module fuzzy_seq_div
  import fuzzy_pkg::*;
#(
  parameter int DVD_W = 22,
  parameter int DVS_W = 12,
  parameter int Q_W   = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);

  localparam int CNT_W = clog2(Q_W) + 1;

  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVS_W-1:0] dvs_q;
  logic [Q_W-1:0]   low_q;
  logic [Q_W-1:0]   quo_q;

  logic [DVS_W-1:0] rem_in_s;
  logic [DVS_W-1:0] dvs_s;
  logic             bit_in_s;
  logic [DVS_W:0]   trial_s;
  logic             q_bit_s;
  logic [DVS_W-1:0] rem_d;

  // One restoring step: shift the next dividend bit in and subtract if it fits.
  always_comb begin
    rem_in_s = {DVS_W{1'b0}};
    dvs_s    = {DVS_W{1'b0}};
    bit_in_s = 1'b0;
    if (busy_q) begin
      rem_in_s = rem_q;
      dvs_s    = dvs_q;
      bit_in_s = low_q[Q_W-1];
    end else begin
      rem_in_s = DVS_W'(dividend_i >> Q_W);
      dvs_s    = divisor_i;
      bit_in_s = dividend_i[Q_W-1];
    end
    trial_s = {rem_in_s, bit_in_s};
    if (trial_s >= {1'b0, dvs_s}) begin
      q_bit_s = 1'b1;
      rem_d   = DVS_W'(trial_s - {1'b0, dvs_s});
    end else begin
      q_bit_s = 1'b0;
      rem_d   = trial_s[DVS_W-1:0];
    end
  end

  // Iteration control: load on start, then shift one quotient bit per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      rem_q  <= {DVS_W{1'b0}};
      dvs_q  <= {DVS_W{1'b0}};
      low_q  <= {Q_W{1'b0}};
      quo_q  <= {Q_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= {quo_q[Q_W-2:0], q_bit_s};
        low_q <= {low_q[Q_W-2:0], 1'b0};
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
        end
      end else if (start_i) begin
        rem_q  <= rem_d;
        dvs_q  <= divisor_i;
        quo_q  <= {{(Q_W-1){1'b0}}, q_bit_s};
        low_q  <= {dividend_i[Q_W-2:0], 1'b0};
        cnt_q  <= CNT_W'(Q_W - 1);
        busy_q <= 1'b1;
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/fuzzy_defuzz_centroid.sv
// Centroid defuzzifier: crisp = sum(mu_i * c_i) / sum(mu_i), truncated.
// Serial MAC over the captured bundle, then a serial divider. A bundle whose
// memberships are all zero skips the divide and reports DivZero.
module fuzzy_defuzz_centroid
  import fuzzy_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int MU_W     = 10,
  parameter int POS_W    = 10
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [NUM_SETS*MU_W-1:0]  Mu,
  input  logic [NUM_SETS*POS_W-1:0] SetCenter,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [POS_W-1:0]          OutData,
  output logic                      DivZero,
  output logic                      Busy
);

  localparam int ACC_NUM_W = num_width(NUM_SETS, MU_W, POS_W);
  localparam int ACC_DEN_W = den_width(NUM_SETS, MU_W);
  localparam int IDX_W     = clog2(NUM_SETS) + 1;
  localparam int PROD_W    = MU_W + POS_W;

  defuzz_state_t             state_q;
  logic [NUM_SETS*MU_W-1:0]  mu_q;
  logic [NUM_SETS*POS_W-1:0] ctr_q;
  logic [ACC_NUM_W-1:0]      num_q;
  logic [ACC_DEN_W-1:0]      den_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [POS_W-1:0]          out_data_q;
  logic                      div_zero_q;
  logic                      busy_q;

  logic [MU_W-1:0]      mu_sel_s;
  logic [POS_W-1:0]     ctr_sel_s;
  logic [PROD_W-1:0]    prod_s;
  logic [ACC_NUM_W-1:0] num_d;
  logic [ACC_DEN_W-1:0] den_d;
  logic                 accum_last_s;
  logic                 div_start_s;
  logic                 div_busy_s;
  logic                 div_done_s;
  logic [POS_W-1:0]     div_quo_s;

  // Select the current set and form the next accumulator values.
  always_comb begin
    mu_sel_s  = {MU_W{1'b0}};
    ctr_sel_s = {POS_W{1'b0}};
    for (int i = 0; i < NUM_SETS; i++) begin
      mu_sel_s  = mu_sel_s  | ({MU_W{idx_q == IDX_W'(i)}}  & mu_q[i*MU_W +: MU_W]);
      ctr_sel_s = ctr_sel_s | ({POS_W{idx_q == IDX_W'(i)}} & ctr_q[i*POS_W +: POS_W]);
    end
    prod_s       = PROD_W'(mu_sel_s) * PROD_W'(ctr_sel_s);
    num_d        = num_q + ACC_NUM_W'(prod_s);
    den_d        = den_q + ACC_DEN_W'(mu_sel_s);
    accum_last_s = (idx_q == IDX_W'(NUM_SETS));
    div_start_s  = (state_q == ACCUM) && accum_last_s &&
                   (den_q != {ACC_DEN_W{1'b0}}) && !div_busy_s;
  end

  fuzzy_seq_div #(
    .DVD_W (ACC_NUM_W),
    .DVS_W (ACC_DEN_W),
    .Q_W   (POS_W)
  ) u_div (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .start_i    (div_start_s),
    .dividend_i (num_q),
    .divisor_i  (den_q),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (div_quo_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      mu_q        <= {(NUM_SETS*MU_W){1'b0}};
      ctr_q       <= {(NUM_SETS*POS_W){1'b0}};
      num_q       <= {ACC_NUM_W{1'b0}};
      den_q       <= {ACC_DEN_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {POS_W{1'b0}};
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            mu_q       <= Mu;
            ctr_q      <= SetCenter;
            num_q      <= {ACC_NUM_W{1'b0}};
            den_q      <= {ACC_DEN_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ACCUM: begin
          if (accum_last_s) begin
            if (den_q != {ACC_DEN_W{1'b0}}) begin
              state_q <= DIVIDE;
            end else begin
              out_data_q  <= {POS_W{1'b0}};
              div_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            num_q <= num_d;
            den_q <= den_d;
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DIVIDE: begin
          if (div_done_s) begin
            out_data_q  <= div_quo_s;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= DIVIDE;
          end
        end
        DONE: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign OutData  = out_data_q;
  assign DivZero  = div_zero_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_fuzzy_defuzz_centroid.sv
// Scoreboard bench for the centroid defuzzifier: directed cases, backpressure,
// mid-divide reset and randomized bundles against an arithmetic model.
module tb_fuzzy_defuzz_centroid;

  localparam int NS = 4;
  localparam int MW = 10;
  localparam int PW = 10;

  logic               Clk = 1'b0;
  logic               Rst_n = 1'b0;
  logic               InValid = 1'b0;
  logic               InReady;
  logic [NS*MW-1:0]   Mu = '0;
  logic [NS*PW-1:0]   SetCenter = '0;
  logic               OutValid;
  logic               OutReady = 1'b0;
  logic [PW-1:0]      OutData;
  logic               DivZero;
  logic               Busy;

  fuzzy_defuzz_centroid #(.NUM_SETS(NS), .MU_W(MW), .POS_W(PW)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .InValid   (InValid),
    .InReady   (InReady),
    .Mu        (Mu),
    .SetCenter (SetCenter),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutData   (OutData),
    .DivZero   (DivZero),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit dz;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   or_mode = 0;
  int   acc_cyc = 0;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: weighted average of centres with plain integer arithmetic.
  function automatic exp_t model(input logic [NS*MW-1:0] mu, input logic [NS*PW-1:0] c);
    exp_t   e;
    longint num = 0;
    longint den = 0;
    for (int i = 0; i < NS; i++) begin
      num += longint'(mu[i*MW +: MW]) * longint'(c[i*PW +: PW]);
      den += longint'(mu[i*MW +: MW]);
    end
    e.dz   = (den == 0);
    e.data = (den == 0) ? 0 : int'(num / den);
    e.lat  = (den == 0) ? (1 + NS) : (1 + NS + PW);
    return e;
  endfunction

  function automatic logic [39:0] pack(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  // Downstream ready: always, random, or held low for backpressure.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      case (or_mode)
        0:       OutReady = 1'b1;
        1:       OutReady = 1'($urandom_range(0, 1));
        default: OutReady = 1'b0;
      endcase
    end
  end

  // Monitor: records acceptance time, compares every presented result.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (InValid && InReady) acc_cyc = cyc + 1;
      if (OutValid) begin
        check("inready_low_in_done", int'(InReady), 0);
        check("busy_in_done", int'(Busy), 1);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got OutValid=1 data=%0d, expected no result", OutData);
        end else begin
          if (!prev_valid) check("latency", cyc - acc_cyc, sb[0].lat);
          check("out_data", int'(OutData), sb[0].data);
          check("div_zero", int'(DivZero), int'(sb[0].dz));
          if (OutReady) void'(sb.pop_front());
        end
      end
      prev_valid = OutValid;
    end
  end

  task automatic send(input logic [39:0] mu, input logic [39:0] c);
    int t = 0;
    @(posedge Clk);
    #2;
    while (!InReady && t < 200) begin
      @(posedge Clk);
      #2;
      t++;
    end
    if (!InReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got InReady=0 after %0d cycles, expected 1", t);
      return;
    end
    Mu        = mu;
    SetCenter = c;
    InValid   = 1'b1;
    sb.push_back(model(mu, c));
    @(posedge Clk);
    #2;
    InValid   = 1'b0;
    Mu        = {8'($urandom), 32'($urandom)};
    SetCenter = {8'($urandom), 32'($urandom)};
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !InReady) && t < 400) begin
      @(posedge Clk);
      #2;
      t++;
    end
    if (sb.size() != 0 || !InReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inready"},  int'(InReady),  1);
    check({tag, "_outvalid"}, int'(OutValid), 0);
    check({tag, "_outdata"},  int'(OutData),  0);
    check({tag, "_divzero"},  int'(DivZero),  0);
    check({tag, "_busy"},     int'(Busy),     0);
  endtask

  logic [39:0] cen;
  logic [39:0] rmu;
  logic [39:0] rc;

  initial begin
    cen = pack(2, 5, 9, 14);
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    #1;
    Rst_n = 1'b1;

    // Directed cases.
    send(pack(0, 0, 1023, 0), cen);
    send(pack(512, 512, 0, 0), cen);
    send(pack(0, 0, 0, 0), cen);
    send(pack(0, 0, 0, 1), cen);
    send(pack(1023, 1023, 1023, 1023), pack(1023, 1023, 1023, 1023));
    send(pack(1023, 1, 0, 0), pack(0, 1023, 0, 0));
    wait_idle();

    // Backpressure: result held while ready is low, input pulses ignored.
    or_mode = 2;
    send(pack(300, 0, 700, 20), cen);
    begin
      int t = 0;
      while (!OutValid && t < 60) begin
        @(posedge Clk);
        #2;
        t++;
      end
      check("bp_outvalid_seen", int'(OutValid), 1);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk);
      #2;
      InValid = (i % 2 == 0);
      Mu      = {8'($urandom), 32'($urandom)};
    end
    InValid = 1'b0;
    or_mode = 0;
    wait_idle();

    // Reset in the middle of the divide aborts the transaction.
    send(pack(0, 0, 1023, 0), cen);
    repeat (8) @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("midreset");
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
    repeat (20) @(posedge Clk);
    send(pack(0, 0, 1023, 0), cen);
    wait_idle();

    // Randomized bundles with random downstream readiness.
    or_mode = 1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NS; i++) begin
        rmu[i*MW +: MW] = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
        rc[i*PW +: PW]  = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 9) == 0) rmu = '0;
      send(rmu, rc);
    end
    wait_idle();
    or_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
